// File: rtl/ssd_pkg.sv
// Shared types and constants for the three-digit seven-segment scan driver.
package ssd_pkg;

  typedef enum logic [1:0] {
    S_HUND  = 2'd0,
    S_TENS  = 2'd1,
    S_UNITS = 2'd2
  } digit_state_t;

  // Bit positions on the segment bus {g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_ERR   = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/ssd_digit_decode.sv
// Combinational BCD digit to seven-segment pattern; non-decimal codes show 'E'.
module ssd_digit_decode
  import ssd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_ERR;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Three-digit multiplexed seven-segment scan driver with a one-deep pending buffer.
// Define SSD_LZ_BLANK_EN to blank leading zeros on the hundreds and tens digits.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned GHOST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd_in,
  input  logic        bcd_valid,
  output logic        bcd_ready,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_tick
);

  localparam int PW = (DWELL_CYCLES > 32'd1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST     = PW'(DWELL_CYCLES - 32'd1);
  localparam logic [PW-1:0] PRESC_PRE_LAST = PW'(DWELL_CYCLES - 32'd2);

  logic [PW-1:0] presc;
  logic          wrap;
  logic          ghost;
  digit_state_t  state;
  digit_state_t  state_next;
  logic [11:0]   pending;
  logic          pending_full;
  logic [11:0]   display;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_next;
  logic [2:0]    an_next;
  logic          tick_next;

  assign wrap      = (presc == PRESC_LAST);
  assign ghost     = (32'(presc) < GHOST_CYCLES);
  assign bcd_ready = ~pending_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= {PW{1'b0}};
    end else if (wrap) begin
      presc <= {PW{1'b0}};
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HUND;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_HUND;
    case (state)
      S_HUND:  state_next = wrap ? S_TENS  : S_HUND;
      S_TENS:  state_next = wrap ? S_UNITS : S_TENS;
      S_UNITS: state_next = wrap ? S_HUND  : S_UNITS;
      default: state_next = S_HUND;
    endcase
  end

  always_comb begin
    an_next = 3'b100;
    nibble  = display[11:8];
    blank   = 1'b0;
    case (state)
      S_HUND: begin
        an_next = 3'b100;
        nibble  = display[11:8];
`ifdef SSD_LZ_BLANK_EN
        blank   = (display[11:8] == 4'd0);
`endif
      end
      S_TENS: begin
        an_next = 3'b010;
        nibble  = display[7:4];
`ifdef SSD_LZ_BLANK_EN
        blank   = (display[11:8] == 4'd0) && (display[7:4] == 4'd0);
`endif
      end
      S_UNITS: begin
        an_next = 3'b001;
        nibble  = display[3:0];
      end
      default: begin
        an_next = 3'b100;
        nibble  = display[11:8];
      end
    endcase
  end

  ssd_digit_decode u_decode (
    .digit (nibble),
    .seg   (dec_seg)
  );

  // The tick is looked ahead one cycle so the registered pulse lines up with the wrap out of S_UNITS.
  always_comb begin
    seg_next  = (ghost || blank) ? SEG_BLANK : dec_seg;
    tick_next = (state == S_UNITS) && (presc == PRESC_PRE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= 7'd0;
      an         <= 3'd0;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_next;
      an         <= an_next;
      frame_tick <= tick_next;
    end
  end

  // Display only changes at a frame boundary, so a frame never mixes old and new digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= 12'd0;
      pending_full <= 1'b0;
      display      <= 12'd0;
    end else if (frame_tick && pending_full) begin
      display      <= pending;
      pending_full <= 1'b0;
    end else if (bcd_valid && !pending_full) begin
      pending      <= bcd_in;
      pending_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver with DWELL_CYCLES=4, GHOST_CYCLES=1.
module tb_ssd_scan_driver;

  localparam int DW = 4;
  localparam int GH = 1;
  localparam int FRAME = 3 * DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd_in = 12'h000;
  logic        bcd_valid = 1'b0;
  logic        bcd_ready;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] an;
    logic       ft;
    logic       rdy;
  } exp_t;

  exp_t        sb[$];
  int          m_cnt;
  logic        m_full;
  logic [11:0] m_pend;
  logic [11:0] m_disp;
  logic [6:0]  last_seg [3];
  logic [2:0]  prev_an;

  ssd_scan_driver #(.DWELL_CYCLES(DW), .GHOST_CYCLES(GH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .bcd_valid  (bcd_valid),
    .bcd_ready  (bcd_ready),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int cnt, input logic [11:0] disp);
    int dig;
    dig = cnt / DW;
    if ((cnt % DW) < GH) return 7'h00;
`ifdef SSD_LZ_BLANK_EN
    if (dig == 0 && disp[11:8] == 4'd0) return 7'h00;
    if (dig == 1 && disp[11:8] == 4'd0 && disp[7:4] == 4'd0) return 7'h00;
`endif
    if (dig == 0) return pat(disp[11:8]);
    if (dig == 1) return pat(disp[7:4]);
    return pat(disp[3:0]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_full  = 1'b0;
    m_pend  = 12'h000;
    m_disp  = 12'h000;
    prev_an = 3'b000;
    for (int i = 0; i < 3; i++) last_seg[i] = 7'h00;
  endtask

  // One clock: predict the registered outputs, advance the model, then compare.
  task automatic cycle();
    exp_t e;
    exp_t got;
    int   post;
    post  = (m_cnt + 1) % FRAME;
    e.an  = 3'(3'b100 >> (m_cnt / DW));
    e.seg = model_seg(m_cnt, m_disp);
    if (m_cnt == FRAME - 1 && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end else if (bcd_valid && !m_full) begin
      m_pend = bcd_in;
      m_full = 1'b1;
    end
    e.ft  = (post == FRAME - 1);
    e.rdy = ~m_full;
    m_cnt = post;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("seg", 32'(seg), 32'(got.seg));
    check("an", 32'(an), 32'(got.an));
    check("frame_tick", 32'(frame_tick), 32'(got.ft));
    check("bcd_ready", 32'(bcd_ready), 32'(got.rdy));
    if (an === prev_an) begin
      case (an)
        3'b100:  last_seg[0] = seg;
        3'b010:  last_seg[1] = seg;
        3'b001:  last_seg[2] = seg;
        default: last_seg[0] = last_seg[0];
      endcase
    end
    prev_an = an;
  endtask

  task automatic wait_tick(input int bound);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < bound) begin
      cycle();
      n++;
    end
    check("tick_wait", 32'(frame_tick), 32'd1);
  endtask

  task automatic check_digits(input string tag, input logic [6:0] h, input logic [6:0] t,
                              input logic [6:0] u);
    check({tag, "_hund"}, 32'(last_seg[0]), 32'(h));
    check({tag, "_tens"}, 32'(last_seg[1]), 32'(t));
    check({tag, "_units"}, 32'(last_seg[2]), 32'(u));
  endtask

  initial begin
    int  n;
    logic acc;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_an", 32'(an), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_ready", 32'(bcd_ready), 32'd1);
    rst = 1'b0;
    model_reset();

    cycle();
    check("first_an", 32'(an), 32'h4);
    check("first_ghost", 32'(seg), 32'd0);
    cycle();
    check("first_zero", 32'(seg), 32'h3F);
    n = 0;
    repeat (2 * FRAME) begin
      cycle();
      if (frame_tick === 1'b1) n++;
    end
    check("ticks_per_2_frames", 32'(n), 32'd2);

    bcd_in    = 12'h042;
    bcd_valid = 1'b1;
    cycle();
    bcd_valid = 1'b0;
    check("042_held", 32'(bcd_ready), 32'd0);
    repeat (3 * FRAME) cycle();
`ifdef SSD_LZ_BLANK_EN
    check_digits("show_042", 7'h00, 7'h66, 7'h5B);
`else
    check_digits("show_042", 7'h3F, 7'h66, 7'h5B);
`endif

    bcd_in    = 12'h123;
    bcd_valid = 1'b1;
    cycle();
    bcd_in = 12'h456;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      acc = bcd_ready;
      cycle();
      n++;
    end
    bcd_valid = 1'b0;
    check("456_accepted", 32'(acc), 32'd1);
    check("456_backpressured", 32'(n > 1), 32'd1);
    repeat (FRAME) cycle();
    check_digits("show_123", 7'h06, 7'h5B, 7'h4F);
    repeat (2 * FRAME) cycle();
    check_digits("show_456", 7'h66, 7'h6D, 7'h7D);

    wait_tick(2 * FRAME);
    bcd_in    = 12'h00F;
    bcd_valid = 1'b1;
    cycle();
    bcd_valid = 1'b0;
    check("00F_captured", 32'(bcd_ready), 32'd0);
    repeat (FRAME) cycle();
    check("00F_not_one_frame", 32'(last_seg[2]), 32'h7D);
    repeat (FRAME) cycle();
`ifdef SSD_LZ_BLANK_EN
    check_digits("show_00F", 7'h00, 7'h00, 7'h79);
`else
    check_digits("show_00F", 7'h3F, 7'h3F, 7'h79);
`endif

    wait_tick(2 * FRAME);
    bcd_in    = 12'h789;
    bcd_valid = 1'b1;
    cycle();
    bcd_valid = 1'b0;
    repeat (5) cycle();
    check("pre_rst_tens", 32'(an), 32'h2);
    check("pre_rst_full", 32'(bcd_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_seg", 32'(seg), 32'd0);
    check("async_an", 32'(an), 32'd0);
    check("async_tick", 32'(frame_tick), 32'd0);
    check("async_ready", 32'(bcd_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle();
    check("post_rst_an", 32'(an), 32'h4);
    repeat (2 * FRAME) cycle();
`ifdef SSD_LZ_BLANK_EN
    check_digits("post_rst", 7'h00, 7'h00, 7'h3F);
`else
    check_digits("post_rst", 7'h3F, 7'h3F, 7'h3F);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000: clock cycles each digit stays selected; legal range 2..2^20.
REQ-002 Parameter GHOST_CYCLES, default 16: cycles at the start of each dwell with segments forced off; legal range 0..DWELL_CYCLES-1.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 bcd_in  input  12  three BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 bcd_valid  input  1  bcd_in is offered this cycle.
REQ-007 bcd_ready  output  1  pending slot empty; a transfer occurs when bcd_valid and bcd_ready are both high.
REQ-008 seg  output  7  shared segment bus {g,f,e,d,c,b,a}, active-high.
REQ-009 an  output  3  one-hot digit enable, active-high: an[2] hundreds, an[1] tens, an[0] units.
REQ-010 frame_tick  output  1  one-cycle pulse on the last cycle of the units dwell.

Function
REQ-011 Prescaler counts 0..DWELL_CYCLES-1 and wraps; the wrap cycle advances the digit state.
REQ-012 Digit states S_HUND -> S_TENS -> S_UNITS -> S_HUND; no other transitions; unreachable encodings return to S_HUND.
REQ-013 an SHALL be one-hot for the current state at all times after reset.
REQ-014 seg SHALL be all-zero while prescaler < GHOST_CYCLES, otherwise the decoded digit of the display register for the current state.
REQ-015 Decode: 0-9 standard patterns (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F); codes 10-15 show 'E' (0x79).
REQ-016 seg and an SHALL be registered; they reflect state and prescaler with exactly one cycle of latency.
REQ-017 Accepted bcd_in is written to a pending register and sets pending_full; bcd_ready = !pending_full.
REQ-018 On the frame_tick cycle, if pending_full, the pending register is copied to the display register and pending_full clears; the new value is first shown on the following S_HUND dwell (no torn frames).
REQ-019 Simultaneous frame_tick with empty pending and a valid transfer: the data is captured into pending only and displayed one frame later.
REQ-020 While pending_full, further bcd_valid is ignored (back-pressure); pending is never overwritten.

Reset
REQ-021 Asserting rst SHALL immediately force seg=0, an=0, frame_tick=0, bcd_ready=1 and clear pending_full, pending register, display register and prescaler, with state S_HUND.
REQ-022 After rst deasserts, an=3'b100 from the first registered update; reset mid-frame discards any pending data.

Configuration
REQ-023 Macro SSD_LZ_BLANK_EN defined: a zero hundreds digit is blanked (seg=0), and a zero tens digit is blanked when hundreds is also zero; units is never blanked.
REQ-024 Macro SSD_LZ_BLANK_EN undefined: all three digits are always displayed, including leading zeros.

Structure
REQ-025 Shared package ssd_pkg holds the digit-state enum, the seven-segment pattern constants (0-9, E, BLANK) and the segment bit ordering.
REQ-026 Digit-to-segment decode SHALL be sub-module ssd_digit_decode (4-bit in, 7-bit out, combinational); the scan FSM, prescaler and handshake stay in ssd_scan_driver.

Verification (DWELL_CYCLES=4, GHOST_CYCLES=1)
REQ-027 Reset release -> an=100, seg=0x3F after the ghost cycle; the sequence 100,010,001 repeats every 12 cycles; frame_tick every 12th cycle.
REQ-028 Offer 12'h042 mid-frame -> accepted immediately, bcd_ready low; the display changes only at the next S_HUND: hundreds 0x3F, tens 0x66, units 0x5B (with SSD_LZ_BLANK_EN, hundreds seg=0).
REQ-029 Offer 12'h123 then 12'h456 back-to-back -> second held off (bcd_ready=0) until frame_tick; display shows 123 and then 456 one frame later; no value is lost.
REQ-030 bcd_valid with 12'h00F on the frame_tick cycle with pending empty -> captured; units shows 0x79 two frames later, not one.
REQ-031 rst asserted during the S_TENS dwell with pending_full -> seg=0 and an=0 asynchronously, bcd_ready=1; after release the display shows 000 (or 0 with SSD_LZ_BLANK_EN).
REQ-032 Over every dwell, an is one-hot and seg=0 on the first cycle of each dwell (ghost cycle).
